// File: rtl/traffic_phase_monitor.sv
// Passive checker for the intersection lamp bundle: decodes lamps into phases 1..8,
// tracks phase order and dwell against the nominal plan, and raises sticky error flags.
module traffic_phase_monitor #(
    parameter int T_GREEN  = 40,
    parameter int T_YELLOW = 5,
    parameter int T_LEFT   = 20,
    parameter int TOL      = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      lamps,
    input  logic             clr_err,
    output logic [3:0]       phase,
    output logic             locked,
    output logic [CNT_W-1:0] dwell,
    output logic             cycle_done,
    output logic [15:0]      cycle_cnt,
    output logic             err_conflict,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_dwell,
    output logic [7:0]       err_cnt
);

    typedef enum logic {SYNC, TRACK} state_t;

    localparam logic [CNT_W-1:0] TG  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] TY  = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] TL  = CNT_W'(T_LEFT);
    localparam logic [CNT_W-1:0] TOV = CNT_W'(TOL);

    state_t           state_q;
    logic [3:0]       phase_q;
    logic             locked_q;
    logic [CNT_W-1:0] dwell_q;
    logic             cycle_done_q;
    logic [15:0]      cycle_cnt_q;
    logic             err_conflict_q, err_illegal_q, err_seq_q, err_dwell_q;
    logic [7:0]       err_cnt_q;
    logic [2:0]       prev_cls_q;

    logic [3:0] ns, sn, ew, we;
    logic       conflict, illegal;
    logic [2:0] cls;
    logic [3:0] nxt_phase;
    logic [CNT_W-1:0] t_nom;
    logic       ev_conf_d, ev_ill_d, ev_seq_d, ev_dw_d, stay_d, adv_d, lock_d;
    logic       any_err;

    // Group encoding is {g, y, r, lt}; r+lt is the only legal multi-lamp combination.
    function automatic logic grp_bad(input logic [3:0] g);
        return (g[3] & g[2]) | (g[3] & g[1]) | (g[2] & g[1]);
    endfunction

    function automatic logic grp_go(input logic [3:0] g);
        return g[3] | g[2] | g[0];
    endfunction

    // P2/P8 and P4/P6 share a lamp pattern, so they map to one class code.
    function automatic logic [2:0] phase_cls(input logic [3:0] p);
        case (p)
            4'd8:    return 3'd2;
            4'd6:    return 3'd4;
            default: return p[2:0];
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] nominal(input logic [3:0] p);
        case (p)
            4'd1, 4'd5: return TG;
            4'd3, 4'd7: return TL;
            default:    return TY;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign ns = lamps[15:12];
    assign sn = lamps[11:8];
    assign ew = lamps[7:4];
    assign we = lamps[3:0];

    assign conflict = grp_bad(ns) | grp_bad(sn) | grp_bad(ew) | grp_bad(we) |
                      ((grp_go(ns) | grp_go(sn)) & (grp_go(ew) | grp_go(we)));

    always_comb begin
        cls = 3'd0;
        if (ns == sn && ew == we) begin
            case ({ns, ew})
                8'b1000_0010: cls = 3'd1;
                8'b0100_0010: cls = 3'd2;
                8'b0010_0011: cls = 3'd3;
                8'b0010_0100: cls = 3'd4;
                8'b0010_1000: cls = 3'd5;
                8'b0011_0010: cls = 3'd7;
                default:      cls = 3'd0;
            endcase
        end
    end

    assign illegal   = !conflict && (cls == 3'd0);
    assign nxt_phase = (phase_q == 4'd8) ? 4'd1 : phase_q + 4'd1;
    assign t_nom     = nominal(phase_q);

    // Checks in priority order: conflict > illegal > seq > dwell.
    always_comb begin
        ev_conf_d = 1'b0;
        ev_ill_d  = 1'b0;
        ev_seq_d  = 1'b0;
        ev_dw_d   = 1'b0;
        stay_d    = 1'b0;
        adv_d     = 1'b0;
        lock_d    = 1'b0;
        if (state_q == SYNC) begin
            ev_conf_d = conflict;
            lock_d    = (cls == 3'd1) && (prev_cls_q != 3'd1);
        end else if (conflict) begin
            ev_conf_d = 1'b1;
        end else if (illegal) begin
            ev_ill_d = 1'b1;
        end else if (cls == phase_cls(phase_q)) begin
            if (dwell_q >= t_nom + TOV) ev_dw_d = 1'b1;
            else                        stay_d  = 1'b1;
        end else if (cls == phase_cls(nxt_phase)) begin
            if (dwell_q >= t_nom - TOV) adv_d   = 1'b1;
            else                        ev_dw_d = 1'b1;
        end else begin
            ev_seq_d = 1'b1;
        end
    end

    assign any_err = ev_conf_d | ev_ill_d | ev_seq_d | ev_dw_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SYNC;
            phase_q        <= 4'd0;
            locked_q       <= 1'b0;
            dwell_q        <= '0;
            cycle_done_q   <= 1'b0;
            cycle_cnt_q    <= 16'd0;
            err_conflict_q <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_seq_q      <= 1'b0;
            err_dwell_q    <= 1'b0;
            err_cnt_q      <= 8'd0;
            prev_cls_q     <= 3'd0;
        end else begin
            prev_cls_q     <= cls;
            cycle_done_q   <= 1'b0;
            err_conflict_q <= (err_conflict_q & ~clr_err) | ev_conf_d;
            err_illegal_q  <= (err_illegal_q & ~clr_err) | ev_ill_d;
            err_seq_q      <= (err_seq_q & ~clr_err) | ev_seq_d;
            err_dwell_q    <= (err_dwell_q & ~clr_err) | ev_dw_d;
            if (any_err) err_cnt_q <= sat_inc(err_cnt_q);
            if (any_err) begin
                state_q  <= SYNC;
                phase_q  <= 4'd0;
                locked_q <= 1'b0;
                dwell_q  <= '0;
            end else if (lock_d) begin
                state_q  <= TRACK;
                phase_q  <= 4'd1;
                locked_q <= 1'b1;
                dwell_q  <= CNT_W'(1);
            end else if (stay_d) begin
                dwell_q <= dwell_q + CNT_W'(1);
            end else if (adv_d) begin
                phase_q <= nxt_phase;
                dwell_q <= CNT_W'(1);
                if (phase_q == 4'd8) begin
                    cycle_done_q <= 1'b1;
                    cycle_cnt_q  <= cycle_cnt_q + 16'd1;
                end
            end
        end
    end

    assign phase        = phase_q;
    assign locked       = locked_q;
    assign dwell        = dwell_q;
    assign cycle_done   = cycle_done_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign err_conflict = err_conflict_q;
    assign err_illegal  = err_illegal_q;
    assign err_seq      = err_seq_q;
    assign err_dwell    = err_dwell_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Scoreboard bench for traffic_phase_monitor: the driver queues hand-derived expectations
// per sampled cycle; the monitor compares registered outputs one edge later.
module tb_traffic_phase_monitor;

    localparam logic [15:0] P1  = 16'h8822;
    localparam logic [15:0] P28 = 16'h4422;
    localparam logic [15:0] P3  = 16'h2233;
    localparam logic [15:0] P46 = 16'h2244;
    localparam logic [15:0] P5  = 16'h2288;
    localparam logic [15:0] P7  = 16'h3322;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lamps = 16'h0;
    logic        clr_err = 1'b0;
    logic [3:0]  phase;
    logic        locked;
    logic [7:0]  dwell;
    logic        cycle_done;
    logic [15:0] cycle_cnt;
    logic        err_conflict, err_illegal, err_seq, err_dwell;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    traffic_phase_monitor dut (
        .clk(clk), .rst(rst), .lamps(lamps), .clr_err(clr_err),
        .phase(phase), .locked(locked), .dwell(dwell), .cycle_done(cycle_done),
        .cycle_cnt(cycle_cnt), .err_conflict(err_conflict), .err_illegal(err_illegal),
        .err_seq(err_seq), .err_dwell(err_dwell), .err_cnt(err_cnt)
    );

    typedef struct {
        string       name;
        logic [3:0]  phase;
        logic        locked;
        logic [7:0]  dwell;
        logic        cd;
        logic [15:0] cyc;
        logic [3:0]  err;   // {conflict, illegal, seq, dwell}
        logic [7:0]  ecnt;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    logic [3:0]  e_phase = 0;
    logic        e_locked = 0;
    logic [7:0]  e_dwell = 0;
    logic        e_cd = 0;
    logic [15:0] e_cyc = 0;
    logic [3:0]  e_err = 0;
    logic [7:0]  e_ecnt = 0;

    task automatic drive(input string nm, input logic [15:0] l, input logic r, input logic c);
        exp_t e;
        @(negedge clk);
        rst = r; lamps = l; clr_err = c;
        e.name = nm; e.phase = e_phase; e.locked = e_locked; e.dwell = e_dwell;
        e.cd = e_cd; e.cyc = e_cyc; e.err = e_err; e.ecnt = e_ecnt;
        sbq.push_back(e);
    endtask

    task automatic hold(input string nm, input int p, input logic [15:0] pat, input int n,
                        input bit cd_first);
        for (int i = 1; i <= n; i++) begin
            e_phase = 4'(p); e_locked = 1'b1; e_dwell = 8'(i);
            e_cd = cd_first && (i == 1);
            if (e_cd) e_cyc = e_cyc + 16'd1;
            drive(nm, pat, 1'b0, 1'b0);
        end
        e_cd = 1'b0;
    endtask

    task automatic go_sync();
        e_phase = 0; e_locked = 0; e_dwell = 0; e_cd = 0;
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                m = sbq.pop_front();
                checks++;
                if ({phase, locked, dwell, cycle_done, cycle_cnt,
                     err_conflict, err_illegal, err_seq, err_dwell, err_cnt} !==
                    {m.phase, m.locked, m.dwell, m.cd, m.cyc, m.err, m.ecnt}) begin
                    failures++;
                    $display("FAIL %s: got ph=%0d lk=%0d dw=%0d cd=%0d cyc=%0d err=%b ecnt=%0d, expected ph=%0d lk=%0d dw=%0d cd=%0d cyc=%0d err=%b ecnt=%0d",
                             m.name, phase, locked, dwell, cycle_done, cycle_cnt,
                             {err_conflict, err_illegal, err_seq, err_dwell}, err_cnt,
                             m.phase, m.locked, m.dwell, m.cd, m.cyc, m.err, m.ecnt);
                end
            end
        end
    end

    initial begin
        drive("reset", 16'h0, 1'b1, 1'b0);
        drive("reset", 16'h0, 1'b1, 1'b0);

        // Full nominal cycle and wrap back to P1.
        hold("p1", 1, P1, 40, 0);
        hold("p2", 2, P28, 5, 0);
        hold("p3", 3, P3, 20, 0);
        hold("p4", 4, P46, 5, 0);
        hold("p5", 5, P5, 40, 0);
        hold("p6", 6, P46, 5, 0);
        hold("p7", 7, P7, 20, 0);
        hold("p8", 8, P28, 5, 0);
        hold("wrap", 1, P1, 1, 1);

        go_sync(); e_err = 4'b1000; e_ecnt = 1;
        drive("conflict", 16'h8888, 1'b0, 1'b0);

        hold("relock_seq", 1, P1, 40, 0);
        go_sync(); e_err = 4'b1010; e_ecnt = 2;
        drive("seq", P3, 1'b0, 1'b0);

        hold("relock_short", 1, P1, 40, 0);
        hold("p2_short", 2, P28, 3, 0);
        go_sync(); e_err = 4'b1011; e_ecnt = 3;
        drive("short_dwell", P3, 1'b0, 1'b0);

        hold("p1_long", 1, P1, 41, 0);
        go_sync(); e_ecnt = 4;
        drive("long_dwell", P1, 1'b0, 1'b0);
        drive("no_relock_same_p1", P1, 1'b0, 1'b0);

        e_err = 4'b1000; e_ecnt = 5;
        drive("clr_with_conflict", 16'h8888, 1'b0, 1'b1);
        e_err = 4'b0000;
        drive("clr_only", 16'h0000, 1'b0, 1'b1);
        drive("sync_ignores_illegal", 16'h0000, 1'b0, 1'b0);

        hold("relock_ill", 1, P1, 1, 0);
        go_sync(); e_err = 4'b0100; e_ecnt = 6;
        drive("illegal_dark", 16'h0000, 1'b0, 1'b0);
        hold("relock_mm", 1, P1, 1, 0);
        go_sync(); e_ecnt = 7;
        drive("illegal_mismatch", 16'h8222, 1'b0, 1'b0);

        hold("run_p1", 1, P1, 40, 0);
        hold("run_p2", 2, P28, 5, 0);
        hold("run_p3", 3, P3, 20, 0);
        hold("run_p4", 4, P46, 5, 0);
        hold("run_p5", 5, P5, 10, 0);
        go_sync(); e_cyc = 0; e_err = 0; e_ecnt = 0;
        drive("reset_mid_p5", P5, 1'b1, 1'b0);
        drive("post_reset_p5", P5, 1'b0, 1'b0);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        #2;
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
